uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised UART receiver for the serial I/O subsystem. It replaces the fixed 8N1 receiver with one that supports configurable data width, parity and stop bits. Bit sampling uses a 3-sample majority vote at mid-bit, start-bit glitches are rejected, and the block recovers from line errors instead of locking up. Received words go to the downstream consumer over a valid/ready handshake, with per-word error sideband and an overrun indication.

## Interface
- CLKS_PER_BIT, 5208, clk cycles per bit (9600 baud at 50 MHz); legal range ≥ 8
- DATA_BITS, 8, data bits per frame; legal range 5–9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits per frame; 1 or 2
- clk  input  1  clock
- arst_n  input  1  reset, asynchronous, active-low
- rx  input  1  serial line, asynchronous to clk, idle high
- rx_data  output  DATA_BITS  received word, LSB = first bit on the line
- rx_valid  output  1  rx_data and error flags are valid; held until accepted
- rx_ready  input  1  consumer accepts the word when rx_valid && rx_ready
- parity_err  output  1  parity mismatch for the held word; constant 0 when PARITY = 0
- frame_err  output  1  any stop bit sampled low for the held word
- overrun  output  1  one-cycle pulse: a completed frame was dropped

## Operation
- rx passes through a 2-flop synchronizer. Both flops reset to 1. All logic uses the synchronized value rxs.
- MID = CLKS_PER_BIT/2 (integer division).
- Bit counter baud_cnt counts 0..CLKS_PER_BIT-1 and wraps to 0 at the end of each bit period.
- Majority vote: sample rxs at baud_cnt = MID-1, MID and MID+1. The bit value is the majority of the three samples. The decision is made at MID+1.
- State machine:
  - IDLE: baud_cnt = 0. A falling edge on rxs (previous 1, current 0) moves to START.
  - START: at the vote, if the bit is 1 (glitch), go to IDLE. If it is 0, continue. At baud_cnt wrap, go to DATA.
  - DATA: shift in the voted bit on each bit period, LSB first. After DATA_BITS bits, go to PAR if PARITY ≠ 0, otherwise go to STOP.
  - PAR: vote the parity bit. At wrap, go to STOP.
    - Odd parity: the data bits plus the parity bit must hold an odd number of 1s.
    - Even parity: the same count must be even.
  - STOP: vote each stop bit.
    - If STOP_BITS = 2, wrap after the first stop bit and vote the second.
    - At the vote of the last stop bit, complete the frame, without waiting for the end of that bit.
    - After completing, go to IDLE if rxs = 1, or to BRK if rxs = 0.
  - BRK: wait for rxs = 1, then go to IDLE. No start edge is accepted while in BRK.
- Frame completion, when rx_valid = 0 or rx_valid && rx_ready in the same cycle:
  - Load rx_data, parity_err and frame_err.
  - Set rx_valid = 1.
- Frame completion when rx_valid = 1 and rx_ready = 0:
  - Discard the new frame.
  - Keep the held word and its flags unchanged.
  - Pulse overrun for 1 cycle.
- A word with frame_err = 1 or parity_err = 1 is still delivered. The consumer decides what to do with it.
- Accept (rx_valid && rx_ready with no completion in the same cycle) clears rx_valid on the next edge. rx_data, parity_err and frame_err keep their values.

## Timing
- Reset values: rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, overrun = 0. The state machine resets to IDLE and baud_cnt to 0.
- Assertion of arst_n mid-frame aborts the frame immediately. No word and no overrun pulse is generated.
- Start edge on the rx pin to START entry: 3 clk cycles (2 synchronizer stages plus the edge register).
- Frame completion occurs at MID+1 of the last stop bit. rx_valid rises on the following clk edge.
- Total frame length is N = 1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS bits.
- Rising edge of rx_valid relative to the start edge on the pin: about (N-1)·CLKS_PER_BIT + MID + 5 cycles.
- Back-to-back frames: a start edge that arrives in the second half of the last stop bit is detected. This gives 0.5 bit of resynchronisation slack per frame.
- rx_ready may be held high permanently. The word is then accepted in the first cycle rx_valid = 1, and rx_valid lasts exactly 1 cycle.
- rx_ready has no combinational path to any output.

## Test plan
- CLKS_PER_BIT = 16, 8N1, send 0xA5 with rx_ready = 1 → one rx_valid pulse, rx_data = 0xA5, both error flags 0.
- Even parity, send 0x3C with the parity bit forced to 1 → rx_data = 0x3C, parity_err = 1. Next, a correct frame 0x01 with parity 1 → parity_err = 0.
- Send 0x55 with the stop bit low, then hold rx low for 3 bit times, then release and send 0x12 → first word 0x55 with frame_err = 1. No start is detected while rx is low. Second word 0x12 with frame_err = 0.
- A 3-cycle low glitch on an idle line → no rx_valid, state returns to IDLE. A 1-cycle low pulse placed at MID of a data bit is outvoted, and the word is unchanged.
- rx_ready = 0, send 0x11 then 0x22 → rx_data = 0x11, overrun pulses for 1 cycle at completion of the second frame. Raising rx_ready accepts 0x11, and rx_valid then drops.
- DATA_BITS = 7, STOP_BITS = 2, odd parity, back-to-back frames 0x7F and 0x00 → both received clean. A second test asserts arst_n in the middle of a data bit, sends 0x33 after release, and expects exactly one word 0x33.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (data width, parity, stop bits).
//
// Each bit is sampled three times around mid-bit and decided by majority
// vote. A start bit that does not hold low through its mid-bit vote is
// rejected as a glitch. A line held low past the frame (break) parks the
// receiver until the line returns high. Completed words are handed to the
// consumer on a valid/ready handshake together with their error flags.
// A word that completes while the previous one is still unaccepted is
// dropped and reported on overrun.
//
// Ports:
//   clk        clock
//   arst_n     asynchronous active-low reset
//   rx         serial line, asynchronous to clk, idle high
//   rx_data    received word, LSB = first data bit on the line
//   rx_valid   rx_data / parity_err / frame_err valid, held until accepted
//   rx_ready   consumer accepts the word when rx_valid && rx_ready
//   parity_err parity mismatch for the held word (0 when PARITY = 0)
//   frame_err  a stop bit of the held word was sampled low
//   overrun    one-cycle pulse: a completed frame was dropped

module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 5208,  // >= 8
    parameter int DATA_BITS    = 8,     // 5..9
    parameter int PARITY       = 0,     // 0 none, 1 odd, 2 even
    parameter int STOP_BITS    = 1      // 1 or 2
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int MID   = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_BRK
    } state_t;

    // Completed word as loaded into the output registers.
    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 perr;
        logic                 ferr;
    } word_t;

    // ------------------------------------------------------------------
    // Synchronizer plus one extra stage for falling-edge detection.
    // All stages reset to the idle level so reset release is not an edge.
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rxs;
    logic rxs_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_q   <= rxs;
        end
    end

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    state_t               state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [3:0]           bit_cnt;
    logic                 stop_cnt;
    logic                 smp0;
    logic                 smp1;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 ferr_acc;   // an earlier stop bit of this frame was low

    logic  at_s0;
    logic  at_s1;
    logic  at_vote;
    logic  at_wrap;
    logic  vote;
    logic  start_edge;
    logic  last_stop;
    logic  par_odd;
    word_t new_word;

    always_comb begin
        at_s0      = (baud_cnt == CNT_S0);
        at_s1      = (baud_cnt == CNT_S1);
        at_vote    = (baud_cnt == CNT_VOTE);
        at_wrap    = (baud_cnt == CNT_LAST);
        // Third sample is the live value at the decision cycle.
        vote       = (smp0 & smp1) | (smp0 & rxs) | (smp1 & rxs);
        start_edge = rxs_q & ~rxs;
        last_stop  = (stop_cnt == STOP_LAST);
        par_odd    = ^{shreg, par_bit};

        new_word.data = shreg;
        new_word.perr = (PARITY == 1) ? ~par_odd :
                        (PARITY == 2) ?  par_odd : 1'b0;
        new_word.ferr = ferr_acc | ~vote;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            smp0       <= 1'b1;
            smp1       <= 1'b1;
            shreg      <= '0;
            par_bit    <= 1'b0;
            ferr_acc   <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;

            // Accept; a completion in the same cycle overrides this below.
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            if (at_s0) smp0 <= rxs;
            if (at_s1) smp1 <= rxs;

            if (state == S_IDLE || state == S_BRK)
                baud_cnt <= '0;
            else if (at_wrap)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (start_edge)
                        state <= S_START;
                end

                S_START: begin
                    if (at_vote && vote) begin
                        // Line did not stay low through mid-bit: glitch.
                        state    <= S_IDLE;
                        baud_cnt <= '0;
                    end else if (at_wrap) begin
                        state    <= S_DATA;
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        ferr_acc <= 1'b0;
                    end
                end

                S_DATA: begin
                    if (at_vote)
                        shreg <= {vote, shreg[DATA_BITS-1:1]};
                    if (at_wrap) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST)
                            state <= (PARITY != 0) ? S_PAR : S_STOP;
                    end
                end

                S_PAR: begin
                    if (at_vote)
                        par_bit <= vote;
                    if (at_wrap)
                        state <= S_STOP;
                end

                S_STOP: begin
                    if (at_vote) begin
                        if (last_stop) begin
                            // Complete at the vote so a back-to-back start
                            // bit in the second half of this bit is seen.
                            if (!rx_valid || rx_ready) begin
                                rx_data    <= new_word.data;
                                parity_err <= new_word.perr;
                                frame_err  <= new_word.ferr;
                                rx_valid   <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                            state    <= rxs ? S_IDLE : S_BRK;
                            baud_cnt <= '0;
                        end else begin
                            ferr_acc <= ferr_acc | ~vote;
                        end
                    end else if (at_wrap) begin
                        stop_cnt <= 1'b1;
                    end
                end

                S_BRK: begin
                    // Line held low: no start detection until it idles.
                    if (rxs)
                        state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three receivers (8N1, 8E1, 7O2) at 16 clk/bit.
// A reference model builds line-level frames and the word each must yield;
// a monitor compares every delivered word and per-cycle output properties.

module tb_uart_rx_cfg;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic [2:0] rx_l = '1;
    logic [2:0] rdy = '1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [6:0] d2;
    logic [2:0] v, pe, fe, ov;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .arst_n(arst_n), .rx(rx_l[0]), .rx_data(d0), .rx_valid(v[0]),
        .rx_ready(rdy[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
        .clk(clk), .arst_n(arst_n), .rx(rx_l[1]), .rx_data(d1), .rx_valid(v[1]),
        .rx_ready(rdy[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
        .clk(clk), .arst_n(arst_n), .rx(rx_l[2]), .rx_data(d2), .rx_valid(v[2]),
        .rx_ready(rdy[2]), .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]));

    int cfg_db[3]  = '{8, 8, 7};
    int cfg_par[3] = '{0, 2, 1};
    int cfg_sb[3]  = '{1, 1, 2};

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         ovr_cnt[3] = '{0, 0, 0};
    int         exp_ovr[3] = '{0, 0, 0};
    int         last_word_cyc[3] = '{0, 0, 0};
    int         start_cyc[3] = '{0, 0, 0};
    logic       prev_v[3] = '{1'b0, 1'b0, 1'b0};
    logic       r_edge[3] = '{1'b0, 1'b0, 1'b0};
    logic [8:0] held_d[3] = '{9'h0, 9'h0, 9'h0};

    // ready as seen by the DUT at each active edge
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) r_edge[i] <= rdy[i];
    end

    initial begin
        #(50000 * 10);
        $display("FAIL watchdog: run did not complete, required finish before 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qpush(input int i, input exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic qpop(input int i, output exp_t e);
        case (i)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic set_rx(input int i, input logic val);
        rx_l[i] = val;
    endtask

    // Model: line levels of one frame and the word it must produce.
    task automatic build(input int i, input logic [8:0] data, input logic pflip,
                         input logic [1:0] slow, output logic [15:0] lv,
                         output int n, output exp_t e);
        int   nones;
        logic pbit;
        lv = '1;
        n = 0;
        nones = 0;
        e = '0;
        lv[n] = 1'b0;
        n++;
        for (int k = 0; k < cfg_db[i]; k++) begin
            lv[n] = data[k];
            e.d[k] = data[k];
            nones += int'(data[k]);
            n++;
        end
        if (cfg_par[i] != 0) begin
            // odd: total ones odd; even: total ones even
            pbit = (cfg_par[i] == 1) ? (nones % 2 == 0) : (nones % 2 == 1);
            pbit ^= pflip;
            lv[n] = pbit;
            n++;
            e.pe = (cfg_par[i] == 1) ? ((nones + int'(pbit)) % 2 == 0)
                                     : ((nones + int'(pbit)) % 2 == 1);
        end
        for (int k = 0; k < cfg_sb[i]; k++) begin
            lv[n] = ~slow[k];
            if (slow[k]) e.fe = 1'b1;
            n++;
        end
    endtask

    task automatic drive(input int i, input logic [15:0] lv, input int n,
                         input int gl_bit, input int gl_off);
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (b == 0 && c == 0) start_cyc[i] = cyc;
                set_rx(i, lv[b] ^ (b == gl_bit && c == gl_off));
            end
        end
    endtask

    task automatic idle(input int i, input int ncyc);
        repeat (ncyc) begin
            @(negedge clk);
            set_rx(i, 1'b1);
        end
    endtask

    task automatic send(input int i, input logic [8:0] data, input logic pflip,
                        input logic [1:0] slow, input int gl_bit, input bit expect_word);
        logic [15:0] lv;
        int          n;
        exp_t        e;
        build(i, data, pflip, slow, lv, n, e);
        if (expect_word) qpush(i, e);
        drive(i, lv, n, gl_bit, 10);
    endtask

    task automatic chk(input int i, input logic vv, input logic [8:0] dd,
                       input logic pp, input logic ff, input logic oo);
        exp_t e;
        if (oo === 1'b1) ovr_cnt[i]++;
        if (vv === 1'b1 && !(prev_v[i] && !r_edge[i])) begin
            last_word_cyc[i] = cyc;
            if (qsize(i) == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word inst%0d: got data=0x%0h required no word", i, dd);
            end else begin
                qpop(i, e);
                check($sformatf("word_data inst%0d", i), 32'(dd), 32'(e.d));
                check($sformatf("word_perr inst%0d", i), 32'(pp), 32'(e.pe));
                check($sformatf("word_ferr inst%0d", i), 32'(ff), 32'(e.fe));
            end
            held_d[i] = dd;
        end else if (vv === 1'b1) begin
            check($sformatf("held_data inst%0d", i), 32'(dd), 32'(held_d[i]));
        end
        if (cfg_par[i] == 0) check($sformatf("perr_zero inst%0d", i), 32'(pp), 32'd0);
        prev_v[i] = vv;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            chk(0, v[0], {1'b0, d0}, pe[0], fe[0], ov[0]);
            chk(1, v[1], {1'b0, d1}, pe[1], fe[1], ov[1]);
            chk(2, v[2], {2'b0, d2}, pe[2], fe[2], ov[2]);
        end
    endtask

    task automatic check_zero(input int i, input logic vv, input logic [8:0] dd,
                              input logic pp, input logic ff, input logic oo);
        check($sformatf("rst_valid inst%0d", i), 32'(vv), 32'd0);
        check($sformatf("rst_data inst%0d", i), 32'(dd), 32'd0);
        check($sformatf("rst_perr inst%0d", i), 32'(pp), 32'd0);
        check($sformatf("rst_ferr inst%0d", i), 32'(ff), 32'd0);
        check($sformatf("rst_ovr inst%0d", i), 32'(oo), 32'd0);
    endtask

    task automatic rand_run(input int i);
        logic [8:0] d;
        logic       pf;
        logic [1:0] sl;
        int         gb;
        for (int k = 0; k < 25; k++) begin
            d = 9'($urandom);
            pf = (cfg_par[i] != 0) && ($urandom_range(0, 7) == 0);
            sl = '0;
            sl[0] = ($urandom_range(0, 7) == 0);
            if (cfg_sb[i] == 2) sl[1] = ($urandom_range(0, 7) == 0);
            gb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, cfg_db[i])) : -1;
            send(i, d, pf, sl, gb, 1'b1);
            // a low final stop bit parks the receiver; give the line time to idle
            if (sl[cfg_sb[i]-1]) idle(i, CPB + int'($urandom_range(0, 10)));
            else idle(i, int'($urandom_range(0, 20)));
        end
    endtask

    initial begin
        logic [15:0] lv;
        int          n;
        exp_t        e;

        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check_zero(0, v[0], {1'b0, d0}, pe[0], fe[0], ov[0]);
        check_zero(1, v[1], {1'b0, d1}, pe[1], fe[1], ov[1]);
        check_zero(2, v[2], {2'b0, d2}, pe[2], fe[2], ov[2]);

        // pin the frame model against hand-derived line levels
        build(0, 9'h0A5, 1'b0, 2'b00, lv, n, e);
        check("model_len_8n1", 32'(n), 32'd10);
        check("model_lv_a5", 32'(lv[9:0]), 32'b1101001010);
        build(2, 9'h000, 1'b0, 2'b00, lv, n, e);
        check("model_len_7o2", 32'(n), 32'd11);
        check("model_lv_00_odd", 32'(lv[10:0]), 32'b11100000000);
        build(1, 9'h03C, 1'b1, 2'b00, lv, n, e);
        check("model_perr_3c", 32'(e.pe), 32'd1);
        check("model_pbit_3c", 32'(lv[9]), 32'd1);

        @(negedge clk);
        arst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 8N1 0xA5, ready high; rx_valid at (N-1)*CPB + MID + 5 after start
        send(0, 9'h0A5, 1'b0, 2'b00, -1, 1'b1);
        idle(0, 2 * CPB);
        check("latency_8n1", 32'(last_word_cyc[0] - start_cyc[0]), 32'd157);

        // even parity: bad parity bit then a correct frame
        send(1, 9'h03C, 1'b1, 2'b00, -1, 1'b1);
        idle(1, 2 * CPB);
        send(1, 9'h001, 1'b0, 2'b00, -1, 1'b1);
        idle(1, 2 * CPB);

        // stop bit low, break for 3 bits, then a clean frame
        send(0, 9'h055, 1'b0, 2'b01, -1, 1'b1);
        repeat (3 * CPB) begin
            @(negedge clk);
            set_rx(0, 1'b0);
        end
        idle(0, 2 * CPB);
        send(0, 9'h012, 1'b0, 2'b00, -1, 1'b1);
        idle(0, 2 * CPB);

        // short start glitch on idle line, then a frame with a 1-cycle data glitch
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            set_rx(0, 1'b0);
        end
        idle(0, 2 * CPB);
        check("glitch_no_word", 32'(qsize(0)), 32'd0);
        send(0, 9'h0FF, 1'b0, 2'b00, 4, 1'b1);
        idle(0, 2 * CPB);

        // overrun: second frame dropped while first is held
        @(negedge clk);
        rdy[0] = 1'b0;
        send(0, 9'h011, 1'b0, 2'b00, -1, 1'b1);
        idle(0, CPB);
        send(0, 9'h022, 1'b0, 2'b00, -1, 1'b0);
        exp_ovr[0] = 1;
        idle(0, 2 * CPB);
        check("overrun_pulses", 32'(ovr_cnt[0]), 32'd1);
        check("ovr_held_valid", 32'(v[0]), 32'd1);
        check("ovr_held_data", 32'(d0), 32'h11);
        rdy[0] = 1'b1;
        @(negedge clk);
        check("accept_valid_drop", 32'(v[0]), 32'd0);
        check("accept_data_kept", 32'(d0), 32'h11);

        // 7O2 back-to-back frames
        send(2, 9'h07F, 1'b0, 2'b00, -1, 1'b1);
        send(2, 9'h000, 1'b0, 2'b00, -1, 1'b1);
        idle(2, 2 * CPB);

        // reset mid data bit aborts the frame
        send(2, 9'h05A, 1'b0, 2'b00, -1, 1'b1);
        idle(2, 2 * CPB);
        build(2, 9'h06C, 1'b0, 2'b00, lv, n, e);
        drive(2, lv, 4, -1, 0);
        repeat (8) begin
            @(negedge clk);
            set_rx(2, lv[4]);
        end
        arst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_zero(2, v[2], {2'b0, d2}, pe[2], fe[2], ov[2]);
        set_rx(2, 1'b1);
        arst_n = 1'b1;
        idle(2, 2 * CPB);
        send(2, 9'h033, 1'b0, 2'b00, -1, 1'b1);
        idle(2, 2 * CPB);

        // randomized frames on all three receivers in parallel
        fork
            rand_run(0);
            rand_run(1);
            rand_run(2);
        join
        idle(0, 2 * CPB);

        for (int t = 0; t < 4000 && (qsize(0) + qsize(1) + qsize(2)) != 0; t++)
            @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("pending_words inst%0d", i), 32'(qsize(i)), 32'd0);
            check($sformatf("overrun_total inst%0d", i), 32'(ovr_cnt[i]), 32'(exp_ovr[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
